fpcvt_decode: RTL

//   Inverse of the 12-bit linear-to-float converter: expands a compact float {S,E,F}

---
 rtl/fpcvt_decode.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fpcvt_decode.sv
`default_nettype none
// ============================================================================
//  Module   : fpcvt_decode
//  Purpose  : Expands a compact float {S,E,F} into a D_W-bit two's-complement
//             value D = (S ? -1 : +1) * (F << E) using a serial shifter that
//             performs one left shift per clock. Input and output both use
//             valid/ready handshakes. Every output is registered.
//  Ports    : clk       - rising-edge clock
//             rst       - asynchronous, active-high reset
//             in_valid  - {S,E,F} valid
//             in_ready  - block can accept (high only while idle)
//             S         - sign, 1 = negative
//             E         - exponent / left-shift count
//             F         - unsigned significand
//             out_valid - D valid, held until taken
//             out_ready - downstream accepts D
//             D         - two's-complement result
//  Revision : 1.0 - initial release
// ============================================================================
module fpcvt_decode #(
  parameter int E_W = 3,
  parameter int F_W = 4,
  parameter int D_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           S,
  input  logic [E_W-1:0] E,
  input  logic [F_W-1:0] F,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D_W-1:0] D
);

  // The result register must hold F shifted by the largest exponent, or the
  // top significand bits would fall off during the shift phase.
  if (D_W < F_W + (1 << E_W)) begin : g_param_check
    $error("fpcvt_decode: D_W must be >= F_W + 2**E_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SIGN  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t         state_q;
  logic [D_W-1:0] mag_q;
  logic [E_W-1:0] cnt_q;
  logic           sgn_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [D_W-1:0] d_q;

  // Next-value helpers for the datapath registers.
  logic [D_W-1:0] mag_load_d;
  logic [D_W-1:0] mag_shl_d;
  logic [E_W-1:0] cnt_dec_d;
  logic [D_W-1:0] d_sign_d;

  assign mag_load_d = {{(D_W-F_W){1'b0}}, F};
  assign mag_shl_d  = mag_q << 1;
  assign cnt_dec_d  = cnt_q - 1'b1;
  // Negating zero gives zero again, so S=1/F=0 never yields a negative zero.
  assign d_sign_d   = sgn_q ? (~mag_q + 1'b1) : mag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mag_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      d_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            mag_q      <= mag_load_d;
            cnt_q      <= E;
            sgn_q      <= S;
            in_ready_q <= 1'b0;
            state_q    <= (E != '0) ? ST_SHIFT : ST_SIGN;
          end
        end
        ST_SHIFT: begin
          mag_q <= mag_shl_d;
          cnt_q <= cnt_dec_d;
          // cnt==1 means this edge performs the final shift.
          if (cnt_q == E_W'(1)) begin
            state_q <= ST_SIGN;
          end
        end
        ST_SIGN: begin
          d_q         <= d_sign_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign D         = d_q;

endmodule
`default_nettype wire
